tx_scheduler: RTL and testbench

- Sequences one signal_gen instance to transmit frames.
- Kicks it off, paces sample consumption at a programmable DAC rate, acknowledges end-of-frame, inserts an inter-frame gap, repeats N times, and supports abort.
- Sits between the host control registers and signal_gen; its outputs feed the DAC interface.

---
 rtl/tx_pkg.sv | 21 ++
 rtl/tx_rate_tick.sv | 36 +++
 rtl/tx_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_tx_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared state encoding and default widths for the transmit scheduler.
package tx_pkg;

  localparam int unsigned DEF_DIV_W    = 16;
  localparam int unsigned DEF_GAP_W    = 16;
  localparam int unsigned DEF_RPT_W    = 8;
  localparam int unsigned DEF_SMP_W    = 13;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned FLUSH_CNT_W  = 2;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_KICK,
    ST_RUN,
    ST_ACK,
    ST_GAP,
    ST_FLUSH
  } tx_state_t;

endpackage

// File: rtl/tx_rate_tick.sv
// Loadable down-counter: tick on terminal count, then reload with the period.
module tx_rate_tick
  import tx_pkg::*;
#(
  parameter int unsigned W = DEF_DIV_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] period_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = period_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? period_i : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// Sequences signal_gen through kick/run/ack/gap per frame, pacing samples to the DAC rate,
// with repeat count, abort flush and sticky status flags.
module tx_scheduler
  import tx_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W,
  parameter int unsigned GAP_W = DEF_GAP_W,
  parameter int unsigned RPT_W = DEF_RPT_W,
  parameter int unsigned SMP_W = DEF_SMP_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [RPT_W-1:0] cfg_repeat,
  input  logic             gen_valid,
  input  logic             gen_done,
  input  logic [SMP_W-1:0] gen_i,
  input  logic [SMP_W-1:0] gen_q,
  output logic             gen_enable,
  output logic             gen_reset,
  output logic [SMP_W-1:0] dac_i,
  output logic [SMP_W-1:0] dac_q,
  output logic             dac_strobe,
  output logic             busy,
  output logic             frame_done,
  output logic             aborted,
  output logic             underrun,
  output logic [RPT_W:0]   frames_sent
);

  tx_state_t               state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic [RPT_W-1:0]        rpt_q, rpt_d;
  logic [RPT_W:0]          frames_q, frames_d, frames_inc;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [SMP_W-1:0]        dac_i_q, dac_i_d;
  logic [SMP_W-1:0]        dac_q_q, dac_q_d;
  logic                    strobe_q, strobe_d;
  logic                    frame_done_q, frame_done_d;
  logic                    aborted_q, aborted_d;
  logic                    underrun_q, underrun_d;
  logic                    busy_q;
  logic                    gen_reset_q;
  logic                    tick, tick_load, tick_en;
  logic                    active, abort_take, last_frame;

  assign active     = (state_q != ST_IDLE) && (state_q != ST_RESET);
  assign abort_take = abort && active;
  assign frames_inc = (frames_q == '1) ? frames_q : frames_q + 1'b1;
  // frames_sent+1 == repeat+1, evaluated without the extra adders
  assign last_frame = (frames_q == {1'b0, rpt_q});
  assign tick_load  = (state_q == ST_KICK);
  assign tick_en    = (state_q == ST_RUN);

  tx_rate_tick #(
    .W (DIV_W)
  ) u_rate_tick (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .load_i   (tick_load),
    .en_i     (tick_en),
    .period_i (div_q),
    .tick_o   (tick)
  );

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    gap_d        = gap_q;
    rpt_d        = rpt_q;
    gap_cnt_d    = gap_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    frames_d     = frames_q;
    dac_i_d      = dac_i_q;
    dac_q_d      = dac_q_q;
    aborted_d    = aborted_q;
    underrun_d   = underrun_q;
    strobe_d     = 1'b0;
    frame_done_d = 1'b0;
    gen_enable   = 1'b0;

    if (abort_take) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = '0;
      aborted_d   = 1'b1;
    end else begin
      case (state_q)
        ST_RESET: state_d = ST_IDLE;
        ST_IDLE: begin
          if (start) begin
            div_d      = cfg_div;
            gap_d      = cfg_gap;
            rpt_d      = cfg_repeat;
            frames_d   = '0;
            aborted_d  = 1'b0;
            underrun_d = 1'b0;
            state_d    = ST_KICK;
          end
        end
        ST_KICK: begin
          gen_enable = 1'b1;
          state_d    = ST_RUN;
        end
        ST_RUN: begin
          strobe_d = tick;
          if (gen_done) begin
            state_d = ST_ACK;
          end else begin
            // a ready sample is held until the tick; otherwise keep signal_gen stepping
            gen_enable = tick || !gen_valid;
            if (tick) begin
              if (gen_valid) begin
                dac_i_d = gen_i;
                dac_q_d = gen_q;
              end else begin
                underrun_d = 1'b1;
              end
            end
          end
        end
        ST_ACK: begin
          gen_enable = 1'b1;
          frames_d   = frames_inc;
          if (last_frame) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else if (gap_q == '0) begin
            state_d = ST_KICK;
          end else begin
            gap_cnt_d = GAP_W'(1);
            state_d   = ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == gap_q) begin
            state_d = ST_KICK;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == FLUSH_CNT_W'(FLUSH_CYCLES - 1)) begin
            state_d = ST_IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RESET;
      div_q        <= '0;
      gap_q        <= '0;
      rpt_q        <= '0;
      gap_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      frames_q     <= '0;
      dac_i_q      <= '0;
      dac_q_q      <= '0;
      strobe_q     <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
      underrun_q   <= 1'b0;
      busy_q       <= 1'b0;
      gen_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      rpt_q        <= rpt_d;
      gap_cnt_q    <= gap_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      frames_q     <= frames_d;
      dac_i_q      <= dac_i_d;
      dac_q_q      <= dac_q_d;
      strobe_q     <= strobe_d;
      frame_done_q <= frame_done_d;
      aborted_q    <= aborted_d;
      underrun_q   <= underrun_d;
      busy_q       <= (state_d != ST_IDLE) && (state_d != ST_RESET);
      gen_reset_q  <= (state_d == ST_FLUSH) || (state_d == ST_RESET);
    end
  end

  assign gen_reset   = gen_reset_q;
  assign dac_i       = dac_i_q;
  assign dac_q       = dac_q_q;
  assign dac_strobe  = strobe_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign aborted     = aborted_q;
  assign underrun    = underrun_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: behavioural signal_gen model plus frame-level reference checks.
module tb_tx_scheduler;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned GAP_W = 16;
  localparam int unsigned RPT_W = 8;
  localparam int unsigned SMP_W = 13;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start, abort;
  logic [DIV_W-1:0] cfg_div;
  logic [GAP_W-1:0] cfg_gap;
  logic [RPT_W-1:0] cfg_repeat;
  logic             gen_valid, gen_done;
  logic [SMP_W-1:0] gen_i, gen_q;
  logic             gen_enable, gen_reset;
  logic [SMP_W-1:0] dac_i, dac_q;
  logic             dac_strobe, busy, frame_done, aborted, underrun;
  logic [RPT_W:0]   frames_sent;

  always #5 clk = ~clk;

  tx_scheduler #(
    .DIV_W (DIV_W),
    .GAP_W (GAP_W),
    .RPT_W (RPT_W),
    .SMP_W (SMP_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .cfg_div     (cfg_div),
    .cfg_gap     (cfg_gap),
    .cfg_repeat  (cfg_repeat),
    .gen_valid   (gen_valid),
    .gen_done    (gen_done),
    .gen_i       (gen_i),
    .gen_q       (gen_q),
    .gen_enable  (gen_enable),
    .gen_reset   (gen_reset),
    .dac_i       (dac_i),
    .dac_q       (dac_q),
    .dac_strobe  (dac_strobe),
    .busy        (busy),
    .frame_done  (frame_done),
    .aborted     (aborted),
    .underrun    (underrun),
    .frames_sent (frames_sent)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // signal_gen model: 0 idle, 1 producing, 2 done
  int g_st = 0, g_idx = 0, g_nsmp = 1, g_stall_at = -1, g_stall = 0;
  logic [SMP_W-1:0] smp_i [64];
  logic [SMP_W-1:0] smp_q [64];
  logic en_s, rst_s, prev_en_done;

  int kick_c[$], ack_c[$], st_c[$];
  logic [SMP_W-1:0] st_i[$], st_q[$];
  int fd_cnt = 0, viol = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    if (rst_s) begin
      g_st = 0; g_stall = 0; gen_valid = 1'b0; gen_done = 1'b0;
    end else begin
      case (g_st)
        0: if (en_s) begin g_st = 1; g_idx = 0; g_stall = 0; end
        1: begin
          if (gen_valid) begin
            if (en_s) begin
              gen_valid = 1'b0;
              g_idx++;
              if (g_idx >= g_nsmp) begin g_st = 2; gen_done = 1'b1; end
              else if (g_idx == g_stall_at) g_stall = 10;
            end
          end else if (g_stall > 0) begin
            g_stall--;
          end else if (en_s) begin
            gen_valid = 1'b1; gen_i = smp_i[g_idx]; gen_q = smp_q[g_idx];
          end
        end
        default: if (en_s) begin g_st = 0; gen_done = 1'b0; end
      endcase
    end
  endtask

  // One clock: monitor at negedge, advance model just after posedge.
  task automatic step();
    @(negedge clk);
    en_s  = gen_enable;
    rst_s = gen_reset;
    if (en_s && !rst_s && g_st == 0) kick_c.push_back(cyc);
    if (en_s && !rst_s && g_st == 2) ack_c.push_back(cyc);
    if (dac_strobe) begin st_c.push_back(cyc); st_i.push_back(dac_i); st_q.push_back(dac_q); end
    if (frame_done) fd_cnt++;
    if (en_s && gen_done && prev_en_done) viol++;
    prev_en_done = en_s && gen_done;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    model_update();
  endtask

  task automatic clear_mon();
    kick_c.delete(); ack_c.delete(); st_c.delete(); st_i.delete(); st_q.delete();
    fd_cnt = 0; viol = 0;
  endtask

  task automatic kick_off(input int div, input int gap, input int rpt, input int n,
                          input int stall_at, input bit with_abort);
    cfg_div = DIV_W'(div); cfg_gap = GAP_W'(gap); cfg_repeat = RPT_W'(rpt);
    g_nsmp = n; g_stall_at = stall_at;
    for (int i = 0; i < n; i++) begin
      smp_i[i] = SMP_W'(($urandom() << 6) | i);
      smp_q[i] = SMP_W'(($urandom() << 6) | (63 - i));
    end
    clear_mon();
    start = 1'b1;
    abort = with_abort;
    step();
    chk("busy_after_start", busy, 1);
    chk("aborted_cleared", aborted, 0);
    chk("underrun_cleared", underrun, 0);
    chk("frames_cleared", frames_sent, 0);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (fd_cnt == 0 && k < budget) begin step(); k++; end
    chk("frame_done_within_budget", (fd_cnt > 0), 1);
  endtask

  task automatic check_run(input int div, input int gap, input int rpt, input int n, input bit stalled);
    int nfr, gap_bad, sp_bad, mism;
    bit same;
    logic [SMP_W-1:0] oi[$], oq[$];
    nfr = rpt + 1;
    chk("frame_done_once", fd_cnt, 1);
    chk("frames_sent", frames_sent, nfr);
    chk("kick_count", kick_c.size(), nfr);
    chk("ack_count", ack_c.size(), nfr);
    gap_bad = 0;
    for (int k = 1; k < nfr && k < kick_c.size() && k <= ack_c.size(); k++)
      if (kick_c[k] - ack_c[k-1] - 1 != gap) gap_bad++;
    chk("gap_spacing_errors", gap_bad, 0);
    sp_bad = 0;
    for (int j = 1; j < st_c.size(); j++) begin
      same = 1'b1;
      foreach (kick_c[k]) if (kick_c[k] > st_c[j-1] && kick_c[k] < st_c[j]) same = 1'b0;
      if (same && (st_c[j] - st_c[j-1] != div + 1)) sp_bad++;
    end
    chk("strobe_spacing_errors", sp_bad, 0);
    for (int j = 0; j < st_i.size(); j++)
      if (!stalled || j == 0 || st_i[j] != st_i[j-1] || st_q[j] != st_q[j-1]) begin
        oi.push_back(st_i[j]); oq.push_back(st_q[j]);
      end
    chk("distinct_sample_count", oi.size(), nfr * n);
    mism = 0;
    for (int j = 0; j < oi.size() && j < nfr * n; j++)
      if (oi[j] !== smp_i[j % n] || oq[j] !== smp_q[j % n]) mism++;
    chk("dac_sequence_errors", mism, 0);
    if (stalled) chk("held_strobes_present", (st_i.size() > n), 1);
    chk("underrun_flag", underrun, stalled);
    chk("busy_after_frame", busy, 0);
    chk("enable_twice_while_done", viol, 0);
  endtask

  logic [SMP_W-1:0] hold_i, hold_q;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_div = '0; cfg_gap = '0; cfg_repeat = '0;
    gen_valid = 1'b0; gen_done = 1'b0; gen_i = '0; gen_q = '0;
    prev_en_done = 1'b0;

    #12;
    chk("rst_gen_reset", gen_reset, 1);
    chk("rst_outputs_zero", {dac_i, dac_q, dac_strobe, gen_enable, frame_done, busy,
                             aborted, underrun, frames_sent}, 0);
    reset_n = 1'b1;
    #1;
    chk("gen_reset_until_first_clock", gen_reset, 1);
    @(posedge clk); #1;
    chk("idle_gen_reset_low", gen_reset, 0);
    chk("idle_busy_low", busy, 0);

    // single frame, 4-clock sample period
    kick_off(3, 0, 0, 8, -1, 1'b0);
    wait_done(2000);
    check_run(3, 0, 0, 8, 1'b0);

    // three frames with a 5-clock gap
    kick_off(2, 5, 2, 4, -1, 1'b0);
    wait_done(2000);
    check_run(2, 5, 2, 4, 1'b0);

    // producer stalls mid-frame
    kick_off(1, 0, 0, 8, 3, 1'b0);
    wait_done(2000);
    check_run(1, 0, 0, 8, 1'b1);

    // abort 20 clocks into RUN
    kick_off(3, 0, 0, 40, -1, 1'b0);
    repeat (21) step();
    abort = 1'b1;
    hold_i = dac_i; hold_q = dac_q;
    #2;
    chk("abort_cycle_enable_low", gen_enable, 0);
    step();
    chk("flush1_gen_reset", gen_reset, 1);
    chk("flush1_busy", busy, 1);
    step();
    chk("flush2_gen_reset", gen_reset, 1);
    step();
    chk("post_flush_gen_reset", gen_reset, 0);
    chk("post_flush_idle", busy, 0);
    chk("aborted_set", aborted, 1);
    chk("abort_dac_i_hold", dac_i, hold_i);
    chk("abort_dac_q_hold", dac_q, hold_q);
    chk("abort_frames_sent", frames_sent, 0);

    kick_off(3, 0, 0, 8, -1, 1'b0);
    wait_done(2000);
    check_run(3, 0, 0, 8, 1'b0);

    // start while busy ignored; start+abort while busy takes abort
    kick_off(2, 0, 0, 30, -1, 1'b0);
    repeat (6) step();
    cfg_div = DIV_W'(7);
    start = 1'b1;
    step();
    repeat (5) step();
    chk("busy_after_ignored_start", busy, 1);
    start = 1'b1; abort = 1'b1;
    step();
    chk("start_abort_busy_flush", gen_reset, 1);
    step(); step();
    chk("start_abort_busy_idle", busy, 0);
    chk("start_abort_busy_aborted", aborted, 1);
    chk("no_restart_kick", kick_c.size(), 1);

    // start+abort from IDLE begins a transmission
    kick_off(2, 1, 1, 5, -1, 1'b1);
    chk("start_abort_idle_no_flush", gen_reset, 0);
    wait_done(2000);
    check_run(2, 1, 1, 5, 1'b0);

    for (int r = 0; r < 3; r++) begin
      int d, g, p, n;
      d = $urandom_range(1, 4); g = $urandom_range(0, 6);
      p = $urandom_range(0, 2); n = $urandom_range(2, 6);
      kick_off(d, g, p, n, -1, 1'b0);
      wait_done(3000);
      check_run(d, g, p, n, 1'b0);
    end

    // asynchronous reset mid-RUN
    kick_off(2, 0, 0, 30, -1, 1'b0);
    repeat (15) step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_gen_reset", gen_reset, 1);
    chk("async_rst_outputs_zero", {dac_i, dac_q, dac_strobe, gen_enable, frame_done, busy,
                                   aborted, underrun, frames_sent}, 0);
    step(); step();
    #2 reset_n = 1'b1;
    step();
    chk("rst_release_gen_reset", gen_reset, 0);
    chk("rst_release_idle", busy, 0);

    kick_off(1, 2, 1, 6, -1, 1'b0);
    wait_done(2000);
    check_run(1, 2, 1, 6, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
